// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: request/response bus between the data-memory bridge and
// the memory system.
//   valid  - request valid (master -> slave)
//   ready  - request accepted (slave -> master)
//   we     - 1 = write, 0 = read (master -> slave)
//   addr   - word-aligned byte address (master -> slave)
//   wdata  - write data (master -> slave)
//   rvalid - read response valid (slave -> master)
//   rdata  - read response data (slave -> master)
interface dmem_bridge_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns a single-cycle core data-memory request into a
// valid/ready bus request with a separate read response, with alignment
// checking and an access timeout.
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   mem_req   - core request (held by the core until done)
//   mem_read  - 1 = load, 0 = store
//   mem_addr  - byte address from the core
//   mem_wdata - store data from the core
//   mem_rdata - load data returned to the core
//   busy      - access in flight on the bus
//   done      - one-cycle completion pulse
//   err       - last access was misaligned or timed out
//   bus       - master side of dmem_bridge_if
module dmem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_read,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  dmem_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] count;
  logic        is_load;
  logic        accept;
  logic        rsp_take;
  logic        abort;
  logic        misaligned;
  logic        timeout_hit;

  assign misaligned  = (mem_addr[1:0] != 2'b00);
  // True when this cycle's increment would make the counter reach TIMEOUT.
  assign timeout_hit = (({1'b0, count} + 17'd1) == 17'(TIMEOUT));

  assign busy      = (state == REQ) || (state == WAIT);
  assign bus.valid = (state == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A handshake or response is checked before the timeout so that a
  // completion landing on the timeout cycle still finishes normally.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    rsp_take   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          accept     = 1'b1;
          state_next = misaligned ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus.ready) begin
          state_next = is_load ? WAIT : DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      WAIT: begin
        if (bus.rvalid) begin
          rsp_take   = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          abort      = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!mem_req) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, count while in flight, and update the
  // load data only on a load response or a load timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 16'd0;
      is_load   <= 1'b0;
      mem_rdata <= 32'd0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= 32'd0;
      bus.wdata <= 32'd0;
    end else begin
      done <= (state_next == DONE) && (state != DONE);
      if (accept) begin
        count     <= 16'd0;
        is_load   <= mem_read;
        err       <= misaligned;
        bus.we    <= !mem_read;
        bus.addr  <= {mem_addr[31:2], 2'b00};
        bus.wdata <= mem_wdata;
      end else if (busy) begin
        count <= count + 16'd1;
      end
      if (rsp_take) begin
        mem_rdata <= bus.rdata;
      end
      if (abort) begin
        err <= 1'b1;
        if (is_load) begin
          mem_rdata <= 32'hDEADBEEF;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed test of dmem_bridge with a transaction-level
// reference model checked every cycle, plus hand-computed expectations.
module tb_dmem_bridge;

  localparam int unsigned TIMEOUT = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  dmem_bridge_if bus_if ();

  dmem_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (bus_if)
  );

  int checks;
  int errors;
  logic cmp_en;

  // Counters of observed DUT bus activity (sampled on falling edges).
  int          hs_cnt;
  int          valid_cnt;
  int          done_cnt;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic        last_we;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: an access is either waiting for its request to be
  // accepted, waiting for read data, or finished and waiting for the core
  // to drop mem_req. Age counts in-flight cycles since acceptance.
  logic        m_req_pend;
  logic        m_rsp_pend;
  logic        m_hold;
  logic        m_load;
  logic        m_err;
  logic        m_done;
  logic        m_we;
  logic [31:0] m_rdata;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  int unsigned m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req_pend = 1'b0;
      m_rsp_pend = 1'b0;
      m_hold     = 1'b0;
      m_load     = 1'b0;
      m_err      = 1'b0;
      m_done     = 1'b0;
      m_we       = 1'b0;
      m_rdata    = 32'd0;
      m_addr     = 32'd0;
      m_wdata    = 32'd0;
      m_age      = 0;
    end else begin
      m_done = 1'b0;
      if (m_hold) begin
        if (!mem_req) m_hold = 1'b0;
      end else if (m_req_pend || m_rsp_pend) begin
        m_age = m_age + 1;
        if (m_req_pend && bus_if.ready) begin
          m_req_pend = 1'b0;
          if (m_load) m_rsp_pend = 1'b1;
          else begin m_hold = 1'b1; m_done = 1'b1; end
        end else if (m_rsp_pend && bus_if.rvalid) begin
          m_rdata    = bus_if.rdata;
          m_rsp_pend = 1'b0;
          m_hold     = 1'b1;
          m_done     = 1'b1;
        end else if (m_age == TIMEOUT) begin
          m_req_pend = 1'b0;
          m_rsp_pend = 1'b0;
          m_err      = 1'b1;
          if (m_load) m_rdata = 32'hDEADBEEF;
          m_hold = 1'b1;
          m_done = 1'b1;
        end
      end else if (mem_req) begin
        m_load  = mem_read;
        m_we    = !mem_read;
        m_addr  = mem_addr & 32'hFFFF_FFFC;
        m_wdata = mem_wdata;
        m_age   = 0;
        if (mem_addr[1:0] != 2'b00) begin
          m_err  = 1'b1;
          m_hold = 1'b1;
          m_done = 1'b1;
        end else begin
          m_err      = 1'b0;
          m_req_pend = 1'b1;
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model.
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check_output("cyc_busy",  32'(busy),  32'(m_req_pend || m_rsp_pend));
        check_output("cyc_valid", 32'(bus_if.valid), 32'(m_req_pend));
        check_output("cyc_done",  32'(done),  32'(m_done));
        check_output("cyc_err",   32'(err),   32'(m_err));
        check_output("cyc_rdata", mem_rdata,  m_rdata);
        if (m_req_pend) begin
          check_output("cyc_bus_addr",  bus_if.addr,  m_addr);
          check_output("cyc_bus_wdata", bus_if.wdata, m_wdata);
          check_output("cyc_bus_we",    32'(bus_if.we), 32'(m_we));
        end
      end
    end
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      if (bus_if.valid) begin
        valid_cnt++;
        last_addr  = bus_if.addr;
        last_wdata = bus_if.wdata;
        last_we    = bus_if.we;
        if (bus_if.ready) hs_cnt++;
      end
      if (done) done_cnt++;
    end
  endtask

  task automatic print_summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  task automatic drive_inputs(input logic req, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic ready, input logic rvalid,
                              input logic [31:0] rdata);
    mem_req       = req;
    mem_read      = rd;
    mem_addr      = addr;
    mem_wdata     = wdata;
    bus_if.ready  = ready;
    bus_if.rvalid = rvalid;
    bus_if.rdata  = rdata;
  endtask

  // Drive one row of inputs just after a rising edge; they are sampled on
  // the following rising edge.
  task automatic apply_stimulus(input logic req, input logic rd, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic ready, input logic rvalid,
                                input logic [31:0] rdata);
    @(posedge clk);
    #1;
    drive_inputs(req, rd, addr, wdata, ready, rvalid, rdata);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic clear_counters();
    hs_cnt    = 0;
    valid_cnt = 0;
    done_cnt  = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_busy"},      32'(busy), 32'd0);
    check_output({tag, "_done"},      32'(done), 32'd0);
    check_output({tag, "_err"},       32'(err),  32'd0);
    check_output({tag, "_rdata"},     mem_rdata, 32'd0);
    check_output({tag, "_valid"},     32'(bus_if.valid), 32'd0);
    check_output({tag, "_bus_we"},    32'(bus_if.we),    32'd0);
    check_output({tag, "_bus_addr"},  bus_if.addr,  32'd0);
    check_output({tag, "_bus_wdata"}, bus_if.wdata, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    clear_counters();
    rst_n = 1'b0;
    drive_inputs(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    fork
      compare_loop();
      monitor_loop();
      begin
        #100000;
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        print_summary();
        $finish;
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    cmp_en = 1'b1;

    // Store 0x100, ready withheld 3 cycles; handshake lands on the timeout cycle.
    $display("[TB] store with delayed ready");
    clear_counters();
    rst_n = 1'b1;
    drive_inputs(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0);
    check_output("first_accept_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle_cycles(2);
    check_output("st_valid_cycles", 32'(valid_cnt), 32'd4);
    check_output("st_handshakes",   32'(hs_cnt),    32'd1);
    check_output("st_done_pulses",  32'(done_cnt),  32'd1);
    check_output("st_bus_we",       32'(last_we),   32'd1);
    check_output("st_bus_addr",     last_addr,      32'h100);
    check_output("st_bus_wdata",    last_wdata,     32'hCAFEF00D);
    check_output("st_rdata",        mem_rdata,      32'd0);
    check_output("st_err",          32'(err),       32'd0);

    // Load 0x200; rvalid during handshake is ignored, real data 2 cycles later.
    $display("[TB] load with late response");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h200, 32'd0, 1'b1, 1'b1, 32'hBAD0BAD0);
    apply_stimulus(1'b1, 1'b1, 32'h200, 32'd0, 1'b1, 1'b1, 32'hBAD1BAD1);
    apply_stimulus(1'b1, 1'b1, 32'h200, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h200, 32'd0, 1'b0, 1'b1, 32'h12345678);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle_cycles(2);
    check_output("ld_rdata",       mem_rdata,     32'h12345678);
    check_output("ld_err",         32'(err),      32'd0);
    check_output("ld_done_pulses", 32'(done_cnt), 32'd1);
    check_output("ld_bus_we",      32'(last_we),  32'd0);

    // Load whose response never comes: times out while waiting for data.
    $display("[TB] load timing out while waiting for data");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h400, 32'd0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h400, 32'd0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h400, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("wto_busy_before", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("wto_done", 32'(done), 32'd1);
    check_output("wto_busy", 32'(busy), 32'd0);
    idle_cycles(2);
    check_output("wto_rdata",      mem_rdata,      32'hDEADBEEF);
    check_output("wto_err",        32'(err),       32'd1);
    check_output("wto_valid_cyc",  32'(valid_cnt), 32'd1);

    // Aligned load with immediate ready and rvalid: done after the third edge.
    $display("[TB] minimum latency load");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h204, 32'd0, 1'b1, 1'b1, 32'hA5A50001);
    apply_stimulus(1'b1, 1'b1, 32'h204, 32'd0, 1'b1, 1'b1, 32'hA5A50001);
    check_output("lat_e0_done", 32'(done), 32'd0);
    check_output("lat_e0_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b1, 1'b1, 32'h204, 32'd0, 1'b1, 1'b1, 32'hA5A50001);
    check_output("lat_e1_done", 32'(done), 32'd0);
    check_output("lat_e1_busy", 32'(busy), 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("lat_e2_done",  32'(done), 32'd1);
    check_output("lat_e2_busy",  32'(busy), 32'd0);
    check_output("lat_e2_rdata", mem_rdata, 32'hA5A50001);
    check_output("lat_e2_err",   32'(err),  32'd0);
    idle_cycles(2);

    // Misaligned load: no bus activity, error and a single done pulse.
    $display("[TB] misaligned load");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h203, 32'd0, 1'b1, 1'b1, 32'h55555555);
    apply_stimulus(1'b1, 1'b1, 32'h203, 32'd0, 1'b1, 1'b1, 32'h55555555);
    check_output("mis_busy", 32'(busy), 32'd0);
    check_output("mis_done", 32'(done), 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle_cycles(2);
    check_output("mis_valid_cyc",  32'(valid_cnt), 32'd0);
    check_output("mis_err",        32'(err),       32'd1);
    check_output("mis_done_cnt",   32'(done_cnt),  32'd1);
    check_output("mis_rdata",      mem_rdata,      32'hA5A50001);

    // Load with ready stuck low: request dropped after TIMEOUT cycles.
    $display("[TB] load timing out on request");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 32'h300, 32'd0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    idle_cycles(2);
    check_output("rto_valid_cyc", 32'(valid_cnt), 32'd4);
    check_output("rto_handshake", 32'(hs_cnt),    32'd0);
    check_output("rto_err",       32'(err),       32'd1);
    check_output("rto_rdata",     mem_rdata,      32'hDEADBEEF);
    check_output("rto_done_cnt",  32'(done_cnt),  32'd1);

    // Held mem_req issues one transaction; drop and re-raise issues another.
    $display("[TB] held request");
    clear_counters();
    apply_stimulus(1'b1, 1'b0, 32'h500, 32'h11112222, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h500, 32'h11112222, 1'b1, 1'b0, 32'd0);
    check_output("held_err_cleared", 32'(err), 32'd0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 32'h500, 32'h11112222, 1'b1, 1'b0, 32'd0);
    check_output("held_handshakes", 32'(hs_cnt),   32'd1);
    check_output("held_done_cnt",   32'(done_cnt), 32'd1);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h504, 32'h33334444, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b0, 32'h504, 32'h33334444, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    idle_cycles(2);
    check_output("rearm_handshakes", 32'(hs_cnt),   32'd2);
    check_output("rearm_done_cnt",   32'(done_cnt), 32'd2);
    check_output("rearm_bus_addr",   last_addr,     32'h504);
    check_output("rearm_bus_wdata",  last_wdata,    32'h33334444);

    // Reset pulsed while waiting for load data; late rvalid is ignored.
    $display("[TB] reset during wait");
    clear_counters();
    apply_stimulus(1'b1, 1'b1, 32'h600, 32'd0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h600, 32'd0, 1'b1, 1'b0, 32'd0);
    apply_stimulus(1'b1, 1'b1, 32'h600, 32'd0, 1'b0, 1'b0, 32'd0);
    check_output("rst_pre_busy",  32'(busy), 32'd1);
    check_output("rst_pre_rdata", mem_rdata, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    check_reset_values("rst_async");
    apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h77777777);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h77777777);
    check_reset_values("rst_after");
    check_output("rst_done_cnt", 32'(done_cnt), 32'd0);
    idle_cycles(2);

    cmp_en = 1'b0;
    print_summary();
    $finish;
  end

endmodule
